// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter: fixed priority (highest index) or round-robin, grant held until ack.
// Optional hold-time watchdog enabled by defining GRANT_TIMEOUT_EN.
module rr_priority_arbiter #(
    parameter int N       = 8,
    parameter int IDXW    = $clog2(N),
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [N-1:0]    req,
    input  logic            ack,
    output logic            any_req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid
`ifdef GRANT_TIMEOUT_EN
    ,
    output logic            timeout
`endif
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_nx;
    logic [IDXW-1:0] win;
    logic [N-1:0]    cand;
    logic            release_now;
    logic            abort_now;
    logic            expire;

    // mode 0: highest set bit; mode 1: lowest set bit >= p, else lowest set bit overall
    function automatic logic [IDXW-1:0] pick(input logic [N-1:0] c, input logic m,
                                             input logic [IDXW-1:0] p);
        logic [IDXW-1:0] w;
        w = '0;
        if (!m) begin
            for (int k = 0; k < N; k++)
                if (c[k]) w = IDXW'(k);
        end else begin
            for (int k = N - 1; k >= 0; k--)
                if (c[k]) w = IDXW'(k);
            for (int k = N - 1; k >= 0; k--)
                if (c[k] && (k >= int'(p))) w = IDXW'(k);
        end
        return w;
    endfunction

    assign any_req = |req;

`ifdef GRANT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] hold_cnt;
    assign expire = (state == GRANT) && !ack && req[gnt_idx] && (hold_cnt == CW'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        release_now = (state == GRANT) && (ack || expire);
        abort_now   = (state == GRANT) && !ack && !req[gnt_idx];
        ptr_nx      = ptr;
        if (release_now && mode)
            ptr_nx = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + IDXW'(1);
        // the releasing holder sits out this one arbitration
        cand = (state == GRANT) ? (req & ~gnt) : req;
        win  = pick(cand, mode, ptr_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
`ifdef GRANT_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
`ifdef GRANT_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= GRANT;
                        gnt       <= {{(N-1){1'b0}}, 1'b1} << win;
                        gnt_idx   <= win;
                        gnt_valid <= 1'b1;
`ifdef GRANT_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr <= ptr_nx;
`ifdef GRANT_TIMEOUT_EN
                        timeout  <= expire;
                        hold_cnt <= '0;
`endif
                        if (|cand) begin
                            gnt     <= {{(N-1){1'b0}}, 1'b1} << win;
                            gnt_idx <= win;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_idx   <= '0;
                            gnt_valid <= 1'b0;
                        end
                    end else if (abort_now) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                    end else begin
`ifdef GRANT_TIMEOUT_EN
                        hold_cnt <= hold_cnt + CW'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: directed literal checks plus a randomized run against
// a holder/pointer model compared on every falling clock edge.
module tb_rr_priority_arbiter;

    localparam int N       = 8;
    localparam int IDXW    = $clog2(N);
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mode = 1'b0;
    logic [N-1:0]    req = '0;
    logic            ack = 1'b0;
    logic            any_req;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
`ifdef GRANT_TIMEOUT_EN
    logic            timeout;
`endif

    rr_priority_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .req(req), .ack(ack),
        .any_req(any_req), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
`ifdef GRANT_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who holds the grant (-1 = nobody), the rotation start, cycles held, timeout pulse.
    int m_holder = -1;
    int m_ptr    = 0;
    int m_held   = 0;
    int m_pulse  = 0;

    function automatic int choose(input logic [N-1:0] c, input logic m, input int p);
        if (!m) begin
            for (int k = N - 1; k >= 0; k--) if (c[k]) return k;
        end else begin
            for (int i = 0; i < N; i++) if (c[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_release(input logic tmo);
        logic [N-1:0] c;
        if (mode) m_ptr = (m_holder + 1) % N;
        c = req;
        c[m_holder] = 1'b0;
        m_holder = choose(c, mode, m_ptr);
        m_held   = 0;
        m_pulse  = tmo ? 1 : 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_holder = -1; m_ptr = 0; m_held = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (m_holder < 0) begin
                m_holder = choose(req, mode, m_ptr);
                m_held   = 0;
            end else if (ack) begin
                model_release(1'b0);
            end else if (!req[m_holder]) begin
                m_holder = -1;
            end else begin
                m_held++;
`ifdef GRANT_TIMEOUT_EN
                if (m_held == TIMEOUT) model_release(1'b1);
`endif
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt",       int'(gnt),       m_holder < 0 ? 0 : (1 << m_holder));
        chk("gnt_idx",   int'(gnt_idx),   m_holder < 0 ? 0 : m_holder);
        chk("gnt_valid", int'(gnt_valid), m_holder < 0 ? 0 : 1);
        chk("any_req",   int'(any_req),   req != 0 ? 1 : 0);
`ifdef GRANT_TIMEOUT_EN
        chk("timeout",   int'(timeout),   m_pulse);
`endif
    end

    task automatic step(input logic m, input logic [N-1:0] r, input logic a);
        mode = m; req = r; ack = a;
        @(posedge clk);
        #2;
    endtask

    int regime;

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step(0, 8'h00, 0);
        chk("idle_valid", int'(gnt_valid), 0);
        chk("idle_any", int'(any_req), 0);

        step(0, 8'b0010_1100, 0);
        chk("fp_gnt", int'(gnt), 8'b0010_0000);
        chk("fp_idx", int'(gnt_idx), 5);
        step(0, 8'b0000_1100, 1);
        chk("fp_b2b_idx", int'(gnt_idx), 3);
        chk("fp_b2b_valid", int'(gnt_valid), 1);
        step(0, 8'h00, 1);
        chk("fp_idle", int'(gnt_valid), 0);

        step(1, 8'hFF, 0);
        chk("rr_first", int'(gnt_idx), 0);
        for (int i = 1; i <= N; i++) begin
            step(1, 8'hFF, 1);
            chk("rr_rot", int'(gnt_idx), i % N);
        end
        step(1, 8'h00, 1);

        step(1, 8'h20, 0);
        chk("rr_to5", int'(gnt_idx), 5);
        step(1, 8'h00, 1);
        step(1, 8'b0000_0101, 0);
        chk("rr_wrap", int'(gnt_idx), 0);
        step(1, 8'b0000_0101, 1);
        chk("rr_skip", int'(gnt_idx), 2);
        step(1, 8'h00, 1);

        step(1, 8'h10, 0);
        chk("ab_grant", int'(gnt_idx), 4);
        step(1, 8'h00, 0);
        chk("ab_idle_gnt", int'(gnt), 0);
        chk("ab_idle_valid", int'(gnt_valid), 0);
        step(1, 8'h10, 0);
        chk("ab_regrant", int'(gnt_idx), 4);
        step(1, 8'h00, 1);

`ifdef GRANT_TIMEOUT_EN
        step(1, 8'b0000_0011, 0);
        chk("to_start", int'(gnt_idx), 0);
        for (int i = 1; i < TIMEOUT; i++) begin
            step(1, 8'b0000_0011, 0);
            chk("to_hold", int'(gnt_idx), 0);
            chk("to_quiet", int'(timeout), 0);
        end
        step(1, 8'b0000_0011, 0);
        chk("to_next_idx", int'(gnt_idx), 1);
        chk("to_pulse", int'(timeout), 1);
        step(1, 8'b0000_0011, 0);
        chk("to_pulse_end", int'(timeout), 0);
        step(1, 8'h00, 1);
`endif

        step(0, 8'h80, 0);
        chk("rst_pre", int'(gnt_idx), 7);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_gnt", int'(gnt), 0);
        chk("rst_async_valid", int'(gnt_valid), 0);
        step(0, 8'h00, 0);
        rst_n = 1'b1;
        step(0, 8'h00, 0);
        chk("rst_rel_valid", int'(gnt_valid), 0);
        chk("rst_rel_any", int'(any_req), 0);

        regime = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 40 == 0) regime = $urandom_range(0, 1);
            if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            if (regime == 0) begin
                case ($urandom_range(0, 3))
                    0: req = '0;
                    1: req = N'(1) << $urandom_range(0, N - 1);
                    default: req = N'($urandom);
                endcase
                ack = ($urandom_range(0, 2) == 0);
                mode = $urandom_range(0, 1) == 1;
            end else begin
                if ($urandom_range(0, 29) == 0) req = N'($urandom);
                ack = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 9) == 0) mode = ~mode;
            end
            @(posedge clk);
            #2;
        end
        rst_n = 1'b1;
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Parametrised, registered successor to the combinational generic priority encoder.
- Arbitrates N request lines and issues a held, one-hot grant plus binary index, released by an ack handshake.
- Runtime-selectable mode: fixed priority (highest index wins, same rule as the existing encoder) or round-robin with a rotating pointer.
- Sits in front of any shared resource (bus, memory port) with multiple requesters.

Parameters:
- N, 8, number of requesters; legal N >= 2.
- IDXW, $clog2(N), width of the grant index; derived, do not override.
- TIMEOUT, 16, max grant hold cycles without ack; used only when GRANT_TIMEOUT_EN is defined; legal TIMEOUT >= 1.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- req  input  N  request vector; bit k = requester k.
- ack  input  1  holder finished; sampled only while gnt_valid = 1.
- any_req  output  1  combinational OR of req.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_idx  output  IDXW  registered binary index of the granted requester.
- gnt_valid  output  1  registered; 1 while a grant is held.
- timeout  output  1  one-cycle pulse on forced release; present only with GRANT_TIMEOUT_EN.

Behaviour:
- Reset (rst_n = 0, async): gnt = 0, gnt_idx = 0, gnt_valid = 0, rr pointer ptr = 0, state IDLE, timeout = 0. Outputs stay at these values until the first clk edge after rst_n rises.
- Reset mid-grant: grant dropped immediately. ptr returns to 0; no ack is needed.
- State IDLE, req == 0: stay in IDLE, outputs unchanged (zero).
- State IDLE, req != 0: select a winner W and go to GRANT. At the next edge: gnt = 1<<W, gnt_idx = W, gnt_valid = 1. Latency is 1 cycle from req to grant.
- Winner selection, mode 0: highest set index in the candidate vector.
- Winner selection, mode 1: lowest set index k with k >= ptr. If none, wrap and take the lowest set index overall.
- mode is sampled only at the arbitration edge. A change during GRANT affects the next arbitration only.
- State GRANT, ack = 1:
  - Release the current holder H.
  - In mode 1, ptr <= (H == N-1) ? 0 : H+1. In mode 0, ptr is unchanged.
  - Re-arbitrate in the same cycle over the candidates req & ~(1<<H), using the updated ptr. If any candidate is set, the new grant appears at the next edge (back-to-back, no idle bubble). Otherwise go to IDLE with gnt = 0 and gnt_valid = 0.
- State GRANT, ack = 0, req[H] = 0 (abort): go to IDLE next edge, outputs zeroed, ptr unchanged. No same-cycle re-arbitration.
- State GRANT, ack = 1 and req[H] = 0 in the same cycle: treated as ack. ptr advances.
- State GRANT, ack = 0, req[H] = 1: hold. gnt, gnt_idx and ptr are all stable regardless of other req changes.
- Holder still requesting after ack: it is excluded for that arbitration only. It may re-win at the following arbitration.
- ack while in IDLE is ignored.
- Invariants: gnt is zero or one-hot; gnt_valid == |gnt; gnt_idx == 0 when gnt_valid = 0.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every new grant and increments each GRANT cycle with ack = 0.
  - When the counter reaches TIMEOUT with no ack, release the holder as if acked: ptr advances and re-arbitration is the same.
  - Pulse timeout = 1 for exactly the cycle in which the new grant or idle outputs first appear.
  - ack on the same cycle as expiry is a normal release with no timeout pulse.
- Not defined: no counter and no timeout port; grants are held indefinitely until ack or abort.

Test Plan:
- Reset/idle, N = 8: assert rst_n = 0 mid-grant -> gnt = 0, gnt_valid = 0 immediately (async). Release reset with req = 0 -> outputs stay 0; any_req = 0.
- Fixed priority, mode = 0, req = 8'b0010_1100 -> next edge gnt = 8'b0010_0000, gnt_idx = 5. Ack with req = 8'b0000_1100 -> next edge gnt_idx = 3, no bubble.
- Round-robin rotation, mode = 1, req = 8'hFF held, ack every grant -> gnt_idx sequence 0,1,2,...,7,0 (wrap at N-1). Holder is never granted twice in a row.
- Round-robin skip/wrap: ptr = 6, req = 8'b0000_0101 -> gnt_idx = 0. After ack, ptr = 1 and req = 8'b0000_0101 -> gnt_idx = 2.
- Abort: grant on idx 4, drop req[4] without ack -> IDLE next edge, gnt = 0, ptr unchanged. Re-request 4 -> gnt_idx = 4 again.
- GRANT_TIMEOUT_EN, TIMEOUT = 16, req = 8'b0000_0011, mode = 1, no ack -> idx 0 released after 16 hold cycles. timeout pulses 1 cycle, gnt_idx = 1, ptr = 1.
